// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: one request at a time, byte/half/word/double accesses,
// sign/zero extension, alignment and range checks, read-modify-write for sub-doubleword stores.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_read,
  input  logic [63:0] mem_rdata,
  output logic        mem_write
);

  typedef enum logic [2:0] {IDLE, LD, ST_WR, RMW_RD, RMW_WR, ERR} state_t;

  localparam logic [63:0] LAST_DW = 64'(MEM_BYTES) - 64'd8;

  state_t      state_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] buf_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [63:0] resp_rdata_q;

  logic        misaligned;
  logic        out_of_range;
  logic [5:0]  shamt;
  logic [63:0] shifted;
  logic [63:0] lane_mask;
  logic [63:0] byte_mask;
  logic [63:0] load_d;
  logic [63:0] merge_d;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      2'b11:   misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
    out_of_range = {req_addr[63:3], 3'b000} > LAST_DW;
  end

  always_comb begin
    shamt   = {addr_q[2:0], 3'b000};
    shifted = mem_rdata >> shamt;
    load_d  = shifted;
    case (size_q)
      2'b00:   load_d = uns_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'b01:   load_d = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'b10:   load_d = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_d = shifted;
    endcase
    lane_mask = '1;
    case (size_q)
      2'b00:   lane_mask = 64'h0000_0000_0000_00FF;
      2'b01:   lane_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   lane_mask = 64'h0000_0000_FFFF_FFFF;
      default: lane_mask = '1;
    endcase
    // alignment was checked on accept, so the shifted mask never spills past bit 63
    byte_mask = lane_mask << shamt;
    merge_d   = (mem_rdata & ~byte_mask) | ((wdata_q << shamt) & byte_mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      size_q       <= '0;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      buf_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (misaligned || out_of_range) state_q <= ERR;
            else if (!req_is_store)         state_q <= LD;
            else if (req_size == 2'b11)     state_q <= ST_WR;
            else                            state_q <= RMW_RD;
          end
        end
        LD: begin
          resp_rdata_q <= load_d;
          resp_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        ST_WR: begin
          resp_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        RMW_RD: begin
          buf_q   <= merge_d;
          state_q <= RMW_WR;
        end
        RMW_WR: begin
          resp_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        ERR: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // strobes come straight from the state register so reset kills them immediately
  always_comb begin
    req_ready  = (state_q == IDLE);
    stall      = ~req_ready;
    mem_read   = (state_q == LD) || (state_q == RMW_RD);
    mem_write  = (state_q == ST_WR) || (state_q == RMW_WR);
    mem_addr   = (mem_read || mem_write) ? {addr_q[63:3], 3'b000} : '0;
    mem_wdata  = '0;
    if (state_q == ST_WR)  mem_wdata = wdata_q;
    if (state_q == RMW_WR) mem_wdata = buf_q;
    resp_valid = resp_valid_q;
    resp_err   = resp_err_q;
    resp_rdata = resp_rdata_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a byte-array data memory model.
module tb_load_store_unit;

  localparam int unsigned MEM_BYTES = 64;
  localparam logic [63:0] LAST_DW   = 64'd56;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        stall;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_read;
  logic [63:0] mem_rdata;
  logic        mem_write;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .mem_write(mem_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned cyc     = 0;
  int unsigned accept_cyc = 0;
  int unsigned n_rd = 0;
  int unsigned n_wr = 0;
  int unsigned bad  = 0;
  string       cur_name = "none";
  logic        preload;
  logic [7:0]  mem [MEM_BYTES];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  always_comb begin
    mem_rdata = '0;
    if (mem_addr <= LAST_DW)
      for (int unsigned i = 0; i < 8; i++)
        mem_rdata[8*i +: 8] = mem[int'(mem_addr[5:0]) + int'(i)];
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int unsigned i = 0; i < MEM_BYTES; i++) mem[i] <= 8'd0;
      mem[0] <= 8'd2; mem[8] <= 8'd1; mem[16] <= 8'd3; mem[32] <= 8'd4;
    end else if (mem_write && mem_addr <= LAST_DW) begin
      for (int unsigned i = 0; i < 8; i++)
        mem[int'(mem_addr[5:0]) + int'(i)] <= mem_wdata[8*i +: 8];
    end
  end

  // monitor: strobe accounting and response checking against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_read && mem_write) bad++;
      if ((mem_read || mem_write) && mem_addr > LAST_DW) bad++;
      if (mem_read)  n_rd++;
      if (mem_write) n_wr++;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", {63'd0, resp_valid}, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({cur_name, "_rdata"}, resp_rdata, e.rdata);
          chk({cur_name, "_err"}, {63'd0, resp_err}, {63'd0, e.err});
          chk({cur_name, "_lat"}, 64'(cyc - accept_cyc), 64'(e.lat));
        end
      end
    end
  end

  task automatic issue(input string name, input logic st, input logic [1:0] sz, input logic un,
                       input logic [63:0] a, input logic [63:0] wd, input logic [63:0] exp_rd,
                       input logic exp_err, input int unsigned exp_lat,
                       input int unsigned exp_nrd, input int unsigned exp_nwr);
    int unsigned w;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    if (!req_ready) chk({name, "_ready_wait"}, {63'd0, req_ready}, 64'd1);
    cur_name = name;
    n_rd = 0; n_wr = 0;
    req_valid = 1'b1; req_is_store = st; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd;
    sb.push_back('{rdata: exp_rd, err: exp_err, lat: exp_lat});
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    req_valid = 1'b0;
    chk({name, "_stall"}, {63'd0, stall}, 64'd1);
    w = 0;
    while (sb.size() != 0 && w < 20) begin @(posedge clk); #2; w++; end
    if (sb.size() != 0) begin
      chk({name, "_timeout"}, 64'(sb.size()), 64'd0);
      sb.delete();
    end
    chk({name, "_nread"}, 64'(n_rd), 64'(exp_nrd));
    chk({name, "_nwrite"}, 64'(n_wr), 64'(exp_nwr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    @(posedge clk);
    #1;
    preload = 1'b0;
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    //     name       st    sz     un    addr    wdata                     exp_rdata                 err  lat rd wr
    issue("ld8",      1'b0, 2'b11, 1'b0, 64'd8,  64'd0,                    64'h1,                    1'b0, 1, 1, 0);
    issue("sb3",      1'b1, 2'b00, 1'b0, 64'd3,  64'hFF,                   64'd0,                    1'b0, 2, 1, 1);
    issue("ld0",      1'b0, 2'b11, 1'b0, 64'd0,  64'd0,                    64'h00000000_FF000002,    1'b0, 1, 1, 0);
    issue("lb3",      1'b0, 2'b00, 1'b0, 64'd3,  64'd0,                    64'hFFFFFFFF_FFFFFFFF,    1'b0, 1, 1, 0);
    issue("lbu3",     1'b0, 2'b00, 1'b1, 64'd3,  64'd0,                    64'hFF,                   1'b0, 1, 1, 0);
    issue("lh2",      1'b0, 2'b01, 1'b0, 64'd2,  64'd0,                    64'hFFFFFFFF_FFFFFF00,    1'b0, 1, 1, 0);
    issue("lw2_mis",  1'b0, 2'b10, 1'b0, 64'd2,  64'd0,                    64'd0,                    1'b1, 1, 0, 0);
    issue("ld64_oor", 1'b0, 2'b11, 1'b0, 64'd64, 64'd0,                    64'd0,                    1'b1, 1, 0, 0);
    chk("oor_ready_after", {63'd0, req_ready}, 64'd1);
    issue("sw36",     1'b1, 2'b10, 1'b0, 64'd36, 64'hDEADBEEF_11223344,    64'd0,                    1'b0, 2, 1, 1);
    issue("ld32",     1'b0, 2'b11, 1'b0, 64'd32, 64'd0,                    64'h11223344_00000004,    1'b0, 1, 1, 0);
    issue("lhu38",    1'b0, 2'b01, 1'b1, 64'd38, 64'd0,                    64'h1122,                 1'b0, 1, 1, 0);
    issue("sd40",     1'b1, 2'b11, 1'b0, 64'd40, 64'h80000000_00000001,    64'd0,                    1'b0, 1, 0, 1);
    issue("lw44",     1'b0, 2'b10, 1'b0, 64'd44, 64'd0,                    64'hFFFFFFFF_80000000,    1'b0, 1, 1, 0);
    issue("lwu44",    1'b0, 2'b10, 1'b1, 64'd44, 64'd0,                    64'h80000000,             1'b0, 1, 1, 0);
    issue("sd56",     1'b1, 2'b11, 1'b0, 64'd56, 64'h01234567_89ABCDEF,    64'd0,                    1'b0, 1, 0, 1);
    issue("lbu63",    1'b0, 2'b00, 1'b1, 64'd63, 64'd0,                    64'h01,                   1'b0, 1, 1, 0);
    issue("lb56",     1'b0, 2'b00, 1'b0, 64'd56, 64'd0,                    64'hFFFFFFFF_FFFFFFEF,    1'b0, 1, 1, 0);
    issue("ld57_mis", 1'b0, 2'b11, 1'b0, 64'd57, 64'd0,                    64'd0,                    1'b1, 1, 0, 0);
    issue("lh1_mis",  1'b0, 2'b01, 1'b0, 64'd1,  64'd0,                    64'd0,                    1'b1, 1, 0, 0);
    issue("sw64_oor", 1'b1, 2'b10, 1'b0, 64'd64, 64'h12345678,             64'd0,                    1'b1, 1, 0, 0);

    // reset while the read-modify-write is about to commit
    @(negedge clk);
    cur_name = "rst_rmw";
    req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 64'd16; req_wdata = 64'hFFFF_FFFF_FFFF_ABCD;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rst_rmw_read", {63'd0, mem_read}, 64'd1);
    @(posedge clk);
    #1;
    chk("rst_rmw_write", {63'd0, mem_write}, 64'd1);
    chk("rst_rmw_wdata", mem_wdata, 64'h00000000_0000ABCD);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_rmw_write_drop", {63'd0, mem_write}, 64'd0);
    chk("rst_rmw_no_resp", {63'd0, resp_valid}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    issue("ld16",     1'b0, 2'b11, 1'b0, 64'd16, 64'd0,                    64'h3,                    1'b0, 1, 1, 0);

    repeat (3) @(posedge clk);
    chk("bad_access", 64'(bad), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
